// File: rtl/rsa_top.sv
// rsa_top: sequential modular exponentiation, result = Base^exponent mod N.
// Right-to-left square-and-multiply over all WIDTH exponent bits, each
// modular product built by interleaved shift-add with at most two
// conditional subtractions per multiplier bit. Latency is fixed at
// (WIDTH+1)*(WIDTH+1)+1 edges from the accepting edge to valid.
// Optional feature: define RSA_TOP_BUSY_EN to add a registered busy output.
module rsa_top #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] result,
  output logic             valid
`ifdef RSA_TOP_BUSY_EN
  ,
  output logic             busy
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 2;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, PREP, EXP, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    step;     // multiplier bit position within one product
  logic [CW-1:0]    bit_idx;  // exponent bit currently being processed
  logic [WIDTH-1:0] exp_r;    // captured exponent, shifted right per bit
  logic [WIDTH-1:0] n_r;      // captured modulus
  logic [WIDTH-1:0] mul_sh;   // scanned operand, consumed MSB-first
  logic [WIDTH-1:0] sq;       // running square: Base^(2^i) mod N
  logic [WIDTH-1:0] acc;      // running product
  logic [WIDTH-1:0] r_sq;     // partial remainder of the square / Base reduction
  logic [WIDTH-1:0] r_acc;    // partial remainder of acc*sq
  logic [WIDTH-1:0] mm_sq;
  logic [WIDTH-1:0] mm_acc;

  // One interleaved step: r = 2r + bit*b, then pull back below n.
  // Operands are < n, so 2r+b < 3n and two subtractions always suffice.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] r,
                                                input logic             bit_in,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
    logic [RW-1:0] t;
    logic [RW-1:0] nn;
    // NOTE: blocking assignments here are intentional -- this is pure
    // combinational arithmetic evaluated in order, not state.
    nn = {2'b00, n};
    t  = {1'b0, r, 1'b0} + (bit_in ? {2'b00, b} : '0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  // Both products scan the same operand (sq, or Base during PREP), so one
  // bit stream drives the squaring and the accumulate datapaths in parallel.
  assign mm_sq  = mod_step(r_sq,  mul_sh[WIDTH-1], (state == PREP) ? ONE : sq, n_r);
  assign mm_acc = mod_step(r_acc, mul_sh[WIDTH-1], acc, n_r);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including result, is cleared so the block
      // comes out of reset in a fully defined state.
      state   <= IDLE;
      step    <= '0;
      bit_idx <= '0;
      exp_r   <= '0;
      n_r     <= '0;
      mul_sh  <= '0;
      sq      <= '0;
      acc     <= '0;
      r_sq    <= '0;
      r_acc   <= '0;
      result  <= '0;
      valid   <= 1'b0;
`ifdef RSA_TOP_BUSY_EN
      busy    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            exp_r   <= exponent;
            n_r     <= N;
            mul_sh  <= Base;
            r_sq    <= '0;
            r_acc   <= '0;
            step    <= '0;
            bit_idx <= '0;
            valid   <= 1'b0;
            state   <= PREP;
`ifdef RSA_TOP_BUSY_EN
            busy    <= 1'b1;
`endif
          end
        end

        // Base mod N as modmult(Base, 1); last cycle seeds sq and acc.
        PREP: begin
          if (step == LAST) begin
            sq     <= r_sq;
            acc    <= (n_r > ONE) ? ONE : '0;
            mul_sh <= r_sq;
            r_sq   <= '0;
            r_acc  <= '0;
            step   <= '0;
            state  <= EXP;
          end else begin
            r_sq   <= mm_sq;
            mul_sh <= {mul_sh[WIDTH-2:0], 1'b0};
            step   <= step + 1'b1;
          end
        end

        // WIDTH shift-add cycles per exponent bit, then one update cycle.
        EXP: begin
          if (bit_idx == LAST) begin
            result <= acc;
            valid  <= 1'b1;
            state  <= DONE;
`ifdef RSA_TOP_BUSY_EN
            busy   <= 1'b0;
`endif
          end else if (step == LAST) begin
            sq      <= r_sq;
            if (exp_r[0]) acc <= r_acc;
            exp_r   <= exp_r >> 1;
            mul_sh  <= r_sq;
            r_sq    <= '0;
            r_acc   <= '0;
            step    <= '0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            r_sq   <= mm_sq;
            r_acc  <= mm_acc;
            mul_sh <= {mul_sh[WIDTH-2:0], 1'b0};
            step   <= step + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_top.sv
// tb_rsa_top: directed and randomized runs of rsa_top against a plain
// repeated-multiplication model of Base^exponent mod N.
module tb_rsa_top;

  localparam int W   = 6;
  localparam int LAT = (W + 1) * (W + 1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] Base;
  logic [W-1:0] exponent;
  logic [W-1:0] N;
  logic [W-1:0] result;
  logic         valid;
`ifdef RSA_TOP_BUSY_EN
  logic         busy;
`endif

  int errors = 0;
  int checks = 0;

  rsa_top #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Base     (Base),
    .exponent (exponent),
    .N        (N),
    .result   (result),
    .valid    (valid)
`ifdef RSA_TOP_BUSY_EN
    ,
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: multiply exponent times, reducing each step.
  function automatic longint ref_pow(input longint b, input longint e, input longint n);
    longint r;
    if (n == 0) return 0;
    r = 1 % n;
    for (longint i = 0; i < e; i++) r = (r * (b % n)) % n;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_now();
`ifdef RSA_TOP_BUSY_EN
    return busy;
`else
    return 1'b0;
`endif
  endfunction

  // Accept a run, optionally hold start for `hold` edges and pulse it again
  // at edge `pulse_at`; scramble inputs after capture; check latency, result
  // and (if present) busy duration. exp_res < 0 means use the model.
  task automatic run(input string tag, input int b, input int e, input int n,
                     input longint exp_res, input int hold, input int pulse_at);
    int     edges;
    int     busy_cnt;
    longint want;
    want     = (exp_res < 0) ? ref_pow(b, e, n) : exp_res;
    Base     = W'(b);
    exponent = W'(e);
    N        = W'(n);
    start    = 1'b1;
    tick();                       // accepting edge
    edges    = 0;
    busy_cnt = 0;
    check($sformatf("%s_valid_clr", tag), valid, 0);
    if (busy_now()) busy_cnt++;
    while (!valid && edges < LAT + 20) begin
      start    = ((edges + 1) < hold) || ((edges + 1) == pulse_at);
      Base     = W'($urandom);
      exponent = W'($urandom);
      N        = W'($urandom);
      tick();
      edges++;
      if (busy_now()) busy_cnt++;
    end
    check($sformatf("%s_latency", tag), edges, LAT);
    check($sformatf("%s_result", tag), result, want);
`ifdef RSA_TOP_BUSY_EN
    check($sformatf("%s_busy_cycles", tag), busy_cnt, LAT);
`endif
  endtask

  initial begin
    logic [W-1:0] held_res;
    int           vcnt;
    rst = 1'b1; start = 1'b0; Base = '0; exponent = '0; N = '0;
    repeat (2) tick();
    check("rst_result", result, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy_now(), 0);
    rst = 1'b0;
    tick();
    check("idle_valid", valid, 0);
    check("idle_busy", busy_now(), 0);

    // Directed examples and corners.
    run("ex_23_50_10", 23, 50, 10, 9, 3, -1);
    start = 1'b0;
    held_res = result;
    repeat (3) tick();
    check("done_hold_valid", valid, 1);
    check("done_hold_result", result, held_res);
    run("ex_40_15_36", 40, 15, 36, 28, 1, -1);
    run("ex_43_10_20", 43, 10, 20, 9, 1, -1);
    run("exp0_n7", int'($urandom_range(0, 63)), 0, 7, 1, 1, -1);
    run("n1", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1, 0, 1, -1);
    run("n0", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0, 0, 1, -1);
    run("b63_n63", 63, 5, 63, 0, 1, -1);
    run("b0", 0, 5, 13, 0, 1, -1);
    run("max_all", 63, 63, 62, -1, 1, -1);

    // Randomized operands against the model.
    for (int i = 0; i < 16; i++)
      run($sformatf("rnd%0d", i), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), -1, 1, -1);

    // Start held high: done, then re-accepted on the very next edge.
    run("held_start", 19, 7, 29, -1, LAT + 10, -1);
    tick();
    check("held_restart_valid", valid, 0);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Start pulse with new inputs at edge 20 is ignored.
    run("ignore_pulse", 5, 3, 11, 4, 1, 20);
    start = 1'b0;

    // Second run aborted by reset at edge 30: no valid afterwards.
    Base = 6'd9; exponent = 6'd9; N = 6'd50; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_result", result, 0);
    check("abort_busy", busy_now(), 0);
    vcnt = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      tick();
      if (valid) vcnt++;
    end
    check("abort_no_valid", vcnt, 0);
    check("abort_result_after", result, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
